dsp_fe_lane_seq: RTL and testbench

Bring-up sequencer for the DSP frontend lanes. It drives each lane's glue reset and enable (the `rst_glue`/`en_glue` pair that gates the DES-to-LUT pipeline registers). On a start request it holds all lanes in reset, releases them one at a time in physical bottom-to-top order with a programmable stagger to limit di/dt, then waits a flush interval for the pipeline to fill before signalling done. It sits in the frontend core next to the clockspine and is clocked by the frontend digital clock; its configuration comes from scan.

---
 rtl/dsp_fe_lane_seq_pkg.sv | 29 ++
 rtl/dsp_fe_seq_timer.sv | 29 ++
 rtl/dsp_fe_lane_seq.sv | 163 ++++++++++++++++
 tb/tb_dsp_fe_lane_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_fe_lane_seq_pkg.sv
// Shared frontend definitions: sequencer state encoding, default widths and
// the physical lane order also walked by the scan snake-chain.
package dsp_fe_lane_seq_pkg;

  localparam int LANE_WIDTH_DEF = 16;
  localparam int HOLD_W_DEF     = 8;
  localparam int STAG_W_DEF     = 4;
  localparam int FLUSH_W_DEF    = 6;
  localparam int LANE_IDX_W     = $clog2(LANE_WIDTH_DEF);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ASSERT_RST = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_FLUSH      = 3'd3,
    ST_RUN        = 3'd4
  } dsp_fe_seq_state_e;

  // Bottom-to-top physical placement of the lanes, indexed by release slot.
  localparam logic [LANE_IDX_W-1:0] LANE_PHYSICAL_ORDER [LANE_WIDTH_DEF] = '{
    4'd0,  4'd8,  4'd1,  4'd9,  4'd3,  4'd11, 4'd4,  4'd12,
    4'd5,  4'd13, 4'd6,  4'd14, 4'd7,  4'd15, 4'd10, 4'd2
  };

  function automatic logic seq_is_busy(input dsp_fe_seq_state_e s);
    return (s == ST_ASSERT_RST) || (s == ST_RELEASE) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/dsp_fe_seq_timer.sv
// Loadable down-counter shared by the hold, stagger and flush intervals;
// it parks at zero instead of wrapping.
module dsp_fe_seq_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rstb,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is written with <= only, so every register in the
  // design sees the pre-edge values of the others regardless of block order.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == '0);

endmodule

// File: rtl/dsp_fe_lane_seq.sv
// Frontend lane bring-up sequencer: holds all lane glue in reset, releases the
// lanes one slot at a time in physical order, then waits for the pipe to fill.
module dsp_fe_lane_seq
  import dsp_fe_lane_seq_pkg::*;
#(
  parameter int LANE_WIDTH = LANE_WIDTH_DEF,
  parameter int HOLD_W     = HOLD_W_DEF,
  parameter int STAG_W     = STAG_W_DEF,
  parameter int FLUSH_W    = FLUSH_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rstb,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [LANE_WIDTH-1:0] i_lane_mask,
  input  logic [HOLD_W-1:0]     i_hold_cycles,
  input  logic [STAG_W-1:0]     i_stagger_cycles,
  input  logic [FLUSH_W-1:0]    i_flush_cycles,
  output logic [LANE_WIDTH-1:0] o_rst_glue,
  output logic [LANE_WIDTH-1:0] o_en_glue,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_state
);

  localparam int TMR_W = (HOLD_W > STAG_W) ?
                         ((HOLD_W > FLUSH_W) ? HOLD_W : FLUSH_W) :
                         ((STAG_W > FLUSH_W) ? STAG_W : FLUSH_W);
  localparam logic [LANE_IDX_W-1:0] LAST_SLOT = LANE_IDX_W'(LANE_WIDTH - 1);

  dsp_fe_seq_state_e       r_state;
  dsp_fe_seq_state_e       w_state_nxt;
  logic [LANE_IDX_W-1:0]   r_idx;
  logic [LANE_IDX_W-1:0]   w_slot_idx;
  logic [LANE_IDX_W-1:0]   w_lane;
  logic                    w_slot_entry;
  logic                    w_start_seq;
  logic                    w_load;
  logic [TMR_W-1:0]        w_load_val;
  logic                    w_expire;
  logic [LANE_WIDTH-1:0]   r_mask;
  logic [STAG_W-1:0]       r_stag;
  logic [FLUSH_W-1:0]      r_flush;
  logic [LANE_WIDTH-1:0]   r_rst_glue;
  logic [LANE_WIDTH-1:0]   r_en_glue;

  dsp_fe_seq_timer #(.W(TMR_W)) u_timer (
    .i_clk    (i_clk),
    .i_rstb   (i_rstb),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_slot_entry = 1'b0;
    w_slot_idx   = r_idx;
    w_start_seq  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_nxt = ST_ASSERT_RST;
          w_load      = 1'b1;
          w_load_val  = TMR_W'(i_hold_cycles);
          w_start_seq = 1'b1;
        end
      end
      ST_ASSERT_RST: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_state_nxt  = ST_RELEASE;
          w_load       = 1'b1;
          w_load_val   = TMR_W'(r_stag);
          w_slot_entry = 1'b1;
          w_slot_idx   = '0;
        end
      end
      ST_RELEASE: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_load = 1'b1;
          if (r_idx == LAST_SLOT) begin
            w_state_nxt = ST_FLUSH;
            w_load_val  = TMR_W'(r_flush);
          end else begin
            w_load_val   = TMR_W'(r_stag);
            w_slot_entry = 1'b1;
            w_slot_idx   = r_idx + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (i_start) begin
          w_state_nxt = ST_ASSERT_RST;
          w_load      = 1'b1;
          w_load_val  = TMR_W'(i_hold_cycles);
          w_start_seq = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_lane = LANE_PHYSICAL_ORDER[w_slot_idx];

  // The hold count goes straight into the timer on the start edge, so that
  // load is its latched copy; only mask, stagger and flush need registers.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_mask  <= '0;
      r_stag  <= '0;
      r_flush <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_slot_entry) begin
        r_idx <= w_slot_idx;
      end
      if (w_start_seq) begin
        r_mask  <= i_lane_mask;
        r_stag  <= i_stagger_cycles;
        r_flush <= i_flush_cycles;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_rst_glue <= '1;
      r_en_glue  <= '0;
    end else if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ASSERT_RST)) begin
      r_rst_glue <= '1;
      r_en_glue  <= '0;
    end else if (w_slot_entry && r_mask[w_lane]) begin
      r_rst_glue[w_lane] <= 1'b0;
      r_en_glue[w_lane]  <= 1'b1;
    end
  end

  assign o_rst_glue = r_rst_glue;
  assign o_en_glue  = r_en_glue;
  assign o_state    = r_state;
  assign o_busy     = seq_is_busy(r_state);
  assign o_done     = (r_state == ST_RUN);

endmodule

// File: tb/tb_dsp_fe_lane_seq.sv
// Scoreboard bench for the lane bring-up sequencer: stimulus queues the
// expected output changes, a negedge monitor pops one per observed change.
module tb_dsp_fe_lane_seq;

  logic        clk = 1'b0;
  logic        i_rstb = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [15:0] i_lane_mask = '0;
  logic [7:0]  i_hold_cycles = '0;
  logic [3:0]  i_stagger_cycles = '0;
  logic [5:0]  i_flush_cycles = '0;
  logic [15:0] o_rst_glue;
  logic [15:0] o_en_glue;
  logic        o_busy;
  logic        o_done;
  logic [2:0]  o_state;

  dsp_fe_lane_seq dut (
    .i_clk            (clk),
    .i_rstb           (i_rstb),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_lane_mask      (i_lane_mask),
    .i_hold_cycles    (i_hold_cycles),
    .i_stagger_cycles (i_stagger_cycles),
    .i_flush_cycles   (i_flush_cycles),
    .o_rst_glue       (o_rst_glue),
    .o_en_glue        (o_en_glue),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_state          (o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic [15:0] rst;
    logic [15:0] en;
  } ev_t;

  localparam int ORD [16] = '{0, 8, 1, 9, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15, 10, 2};

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int t, input logic [2:0] st, input logic [15:0] rst_m,
                      input logic [15:0] en_m);
    ev_t e;
    e.cyc = t;
    e.st  = st;
    e.rst = rst_m;
    e.en  = en_m;
    exp_q.push_back(e);
  endtask

  // Expected output changes for one sequence started at edge e0.
  task automatic gen(input int e0, input int h, input int s, input int f,
                     input logic [15:0] mask, input int last_slot,
                     input bit to_flush, input bit to_run);
    logic [15:0] rst_m;
    logic [15:0] en_m;
    int          t;
    rst_m = 16'hFFFF;
    en_m  = 16'h0000;
    push(e0, 3'd1, rst_m, en_m);
    for (int k = 0; k <= last_slot; k++) begin
      t = e0 + h + 1 + k * (s + 1);
      if (mask[ORD[k]]) begin
        rst_m[ORD[k]] = 1'b0;
        en_m[ORD[k]]  = 1'b1;
      end
      if (k == 0 || mask[ORD[k]]) push(t, 3'd2, rst_m, en_m);
    end
    t = e0 + h + 1 + 16 * (s + 1);
    if (to_flush) push(t, 3'd3, rst_m, en_m);
    if (to_run)   push(t + f + 1, 3'd4, rst_m, en_m);
  endtask

  task automatic start_seq(input int h, input int s, input int f, input logic [15:0] mask,
                           input int last_slot, input bit to_flush, input bit to_run,
                           output int e0);
    @(negedge clk);
    i_hold_cycles    = 8'(h);
    i_stagger_cycles = 4'(s);
    i_flush_cycles   = 6'(f);
    i_lane_mask      = mask;
    e0 = cyc + 1;
    gen(e0, h, s, f, mask, last_slot, to_flush, to_run);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every change of the observable outputs must match the next
  // queued expectation, including the edge on which it happened.
  logic [36:0] prev_snap;
  bit          mon_init = 1'b0;
  always @(negedge clk) begin
    logic [36:0] snap;
    ev_t         e;
    logic        eb;
    logic        ed;
    snap = {o_state, o_busy, o_done, o_rst_glue, o_en_glue};
    if (mon_init && snap !== prev_snap) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d st=%0d rst=%h en=%h", cyc, o_state,
                 o_rst_glue, o_en_glue);
      end else begin
        e  = exp_q.pop_front();
        eb = (e.st == 3'd1) || (e.st == 3'd2) || (e.st == 3'd3);
        ed = (e.st == 3'd4);
        if (cyc != e.cyc || o_state !== e.st || o_busy !== eb || o_done !== ed ||
            o_rst_glue !== e.rst || o_en_glue !== e.en) begin
          errors++;
          $display("FAIL event: got cyc=%0d st=%0d busy=%0b done=%0b rst=%h en=%h, want cyc=%0d st=%0d busy=%0b done=%0b rst=%h en=%h",
                   cyc, o_state, o_busy, o_done, o_rst_glue, o_en_glue,
                   e.cyc, e.st, eb, ed, e.rst, e.en);
        end
      end
    end
    prev_snap = snap;
    mon_init  = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e1;
    int e2;
    int e3;

    // Power-on reset.
    #2 i_rstb = 1'b0;
    #1;
    check("por_state", 32'(o_state), 32'd0);
    check("por_rst",   32'(o_rst_glue), 32'h0000FFFF);
    check("por_en",    32'(o_en_glue), 32'd0);
    check("por_busy_done", 32'({o_busy, o_done}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    i_rstb = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal H=3 S=1 F=4: lane 0 @E0+4, lane 8 @E0+6, lane 2 @E0+34,
    // FLUSH @E0+36, RUN @E0+41. Mid-RELEASE start and config changes ignored.
    start_seq(3, 1, 4, 16'hFFFF, 15, 1'b1, 1'b1, e0);
    while (cyc < e0 + 10) @(negedge clk);
    i_start          = 1'b1;
    i_stagger_cycles = 4'd15;
    i_hold_cycles    = 8'd0;
    i_flush_cycles   = 6'd0;
    i_lane_mask      = 16'h0000;
    @(negedge clk);
    i_start = 1'b0;
    wait_drain(100);
    repeat (3) @(negedge clk);
    check("nominal_done", 32'({o_busy, o_done}), 32'd1);

    // Restart from RUN with H=0 S=0 F=0 mask=0x00FF: done at E1+18.
    start_seq(0, 0, 0, 16'h00FF, 15, 1'b1, 1'b1, e1);
    wait_drain(60);
    repeat (2) @(negedge clk);
    check("mask_rst", 32'(o_rst_glue), 32'h0000FF00);
    check("mask_en",  32'(o_en_glue),  32'h000000FF);

    // Abort during FLUSH (FLUSH @E2+17, abort sampled @E2+20).
    start_seq(0, 0, 10, 16'hFFFF, 15, 1'b1, 1'b0, e2);
    while (cyc < e2 + 19) @(negedge clk);
    push(e2 + 20, 3'd0, 16'hFFFF, 16'h0000);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    wait_drain(60);

    // Start and abort together from IDLE, then abort alone: stays IDLE.
    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    i_abort = 1'b0;
    repeat (3) @(negedge clk);
    check("start_abort_idle", 32'(o_state), 32'd0);
    check("start_abort_rst",  32'(o_rst_glue), 32'h0000FFFF);

    // Asynchronous reset mid-RELEASE (H=2 S=3: slot 2 @E3+11).
    start_seq(2, 3, 0, 16'hFFFF, 2, 1'b0, 1'b0, e3);
    do begin
      @(posedge clk);
      #2;
    end while (cyc != e3 + 12);
    push(e3 + 12, 3'd0, 16'hFFFF, 16'h0000);
    i_rstb = 1'b0;
    #1;
    check("async_rst_state", 32'(o_state), 32'd0);
    check("async_rst_rst",   32'(o_rst_glue), 32'h0000FFFF);
    check("async_rst_en",    32'(o_en_glue), 32'd0);
    check("async_rst_busy",  32'({o_busy, o_done}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    i_rstb = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_idle", 32'(o_state), 32'd0);
    wait_drain(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
